if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 132 +++++++++++++
 tb/tb_if_fetch_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a 2-bit bimodal branch predictor.
// Build macro IF_FETCH_BHT_EN enables the branch history table; without it every fetch predicts not-taken.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BHT_ENTRIES = 64
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instruction,
   output logic [1:0]  if_id_bp_state,
   output logic        if_id_valid
);

   localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

   // Control semantics: redirect beats stall everywhere. stall holds the PC and the
   // IF/ID register unchanged; redirect loads redirect_pc and turns IF/ID into a bubble.
   // Predictor updates from EX are never held back by either signal.

   logic [31:0] pc_q;
   logic [31:0] pc_next;
   logic [31:0] pc_plus4;
   logic [31:0] b_imm;
   logic [31:0] br_target;
   logic        is_branch;
   logic        predict_taken;
   logic [1:0]  bp_state;

   assign imem_addr = pc_q;
   assign pc_plus4  = pc_q + 32'd4;

   // B-type immediate: {imm[12], imm[11], imm[10:5], imm[4:1], 0}, sign-extended.
   assign b_imm = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                   imem_rdata[30:25], imem_rdata[11:8], 1'b0};
   assign br_target = pc_q + b_imm;
   assign is_branch = (imem_rdata[6:0] == OPC_BRANCH);

`ifdef IF_FETCH_BHT_EN

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [1:0]       bht [BHT_ENTRIES];
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   logic             unused_upd_bits;

   function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic up);
      logic [1:0] res;
      res = cnt;
      if (up) begin
         if (cnt != 2'b11) res = cnt + 2'd1;
      end else begin
         if (cnt != 2'b00) res = cnt - 2'd1;
      end
      return res;
   endfunction

   assign rd_idx          = pc_q[IDX_W+1:2];
   assign wr_idx          = upd_pc[IDX_W+1:2];
   assign unused_upd_bits = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};

   // Read is asynchronous off the current state, so a same-cycle update to the
   // entry being looked up is seen only from the following fetch.
   assign bp_state      = bht[rd_idx];
   assign predict_taken = is_branch & bp_state[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht[i] <= 2'b01;
         end
      end else if (upd_valid) begin
         bht[wr_idx] <= sat_next(bht[wr_idx], upd_taken);
      end
   end

`else

   localparam int unused_bht_entries = BHT_ENTRIES;

   logic unused_pred_inputs;

   assign bp_state           = 2'b01;
   assign predict_taken      = 1'b0;
   assign unused_pred_inputs = ^{upd_valid, upd_taken, upd_pc, br_target, is_branch};

`endif

   always_comb begin
      pc_next = pc_plus4;
      if (redirect) begin
         pc_next = redirect_pc;
      end else if (stall) begin
         pc_next = pc_q;
      end else if (predict_taken) begin
         pc_next = br_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || redirect) begin
         if_id_pc          <= 32'h0000_0000;
         if_id_instruction <= NOP_INSN;
         if_id_bp_state    <= 2'b00;
         if_id_valid       <= 1'b0;
      end else if (!stall) begin
         if_id_pc          <= pc_q;
         if_id_instruction <= imem_rdata;
         if_id_bp_state    <= bp_state;
         if_id_valid       <= 1'b1;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, sequential fetch, stall, redirect, wrap and
// predictor behaviour (BHT checks are selected by IF_FETCH_BHT_EN, matching the DUT build).
module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] BEQ_P  = 32'h0000_0863;  // beq x0,x0,+16
   localparam logic [31:0] BEQ_N  = 32'hFE00_0CE3;  // beq x0,x0,-8

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instruction;
   logic [1:0]  if_id_bp_state;
   logic        if_id_valid;

   int n_checks = 0;
   int n_fail   = 0;

   if_fetch_unit #(.RESET_PC(RST_PC), .BHT_ENTRIES(64)) dut (
      .clk               (clk),
      .rst               (rst),
      .imem_addr         (imem_addr),
      .imem_rdata        (imem_rdata),
      .stall             (stall),
      .redirect          (redirect),
      .redirect_pc       (redirect_pc),
      .upd_valid         (upd_valid),
      .upd_pc            (upd_pc),
      .upd_taken         (upd_taken),
      .if_id_pc          (if_id_pc),
      .if_id_instruction (if_id_instruction),
      .if_id_bp_state    (if_id_bp_state),
      .if_id_valid       (if_id_valid)
   );

   // ---- clock ----
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

   // ---- instruction memory model: ADDI-style words unique per address, two branches ----
   function automatic logic [31:0] imem_word(input logic [31:0] a);
      case (a)
         32'h0000_0200: return BEQ_P;
         32'h0000_0304: return BEQ_N;
         default:       return {a[19:0], 12'h013};
      endcase
   endfunction

   always_comb imem_rdata = imem_word(imem_addr);

   // ---- driver / checker tasks ----
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_fetch(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc,
                            input logic [1:0] e_bp, input logic e_valid);
      chk({tag, ".imem_addr"}, imem_addr, e_addr);
      chk({tag, ".pc"}, if_id_pc, e_pc);
      chk({tag, ".insn"}, if_id_instruction, imem_word(e_pc));
      chk({tag, ".bp"}, {30'd0, if_id_bp_state}, {30'd0, e_bp});
      chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
   endtask

   task automatic chk_bubble(input string tag, input logic [31:0] e_addr);
      chk({tag, ".imem_addr"}, imem_addr, e_addr);
      chk({tag, ".pc"}, if_id_pc, 32'h0);
      chk({tag, ".insn"}, if_id_instruction, NOP);
      chk({tag, ".bp"}, {30'd0, if_id_bp_state}, 32'h0);
      chk({tag, ".valid"}, {31'd0, if_id_valid}, 32'h0);
   endtask

   // ---- directed sequence ----
   initial begin
`ifdef IF_FETCH_BHT_EN
      logic [1:0]  nt_bp   [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
      logic [31:0] nt_addr [4] = '{32'h210, 32'h204, 32'h204, 32'h204};
`endif
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
      step();
      chk_bubble("reset", RST_PC);

      rst = 1'b0;
      step(); chk_fetch("seq0", 32'h104, 32'h100, 2'b01, 1'b1);
      step(); chk_fetch("seq1", 32'h108, 32'h104, 2'b01, 1'b1);
      step(); chk_fetch("seq2", 32'h10C, 32'h108, 2'b01, 1'b1);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); chk_fetch("stall_hold", 32'h10C, 32'h108, 2'b01, 1'b1);
      end
      stall = 1'b0;
      step(); chk_fetch("stall_release", 32'h110, 32'h10C, 2'b01, 1'b1);

      redirect = 1'b1; redirect_pc = 32'h400; stall = 1'b1;
      step(); chk_bubble("redir_and_stall", 32'h400);
      redirect = 1'b0; stall = 1'b0;
      step(); chk_fetch("after_redir", 32'h404, 32'h400, 2'b01, 1'b1);

      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step(); chk_bubble("redir_top", 32'hFFFF_FFFC);
      redirect = 1'b0;
      step(); chk_fetch("pc_wrap", 32'h0, 32'hFFFF_FFFC, 2'b01, 1'b1);

      rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h400; stall = 1'b1;
      upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1;
      step(); chk_bubble("rst_override", RST_PC);
      rst = 1'b0; redirect = 1'b0; stall = 1'b0; upd_valid = 1'b0;
      step(); chk_fetch("post_rst", 32'h104, 32'h100, 2'b01, 1'b1);

`ifdef IF_FETCH_BHT_EN
      redirect = 1'b1; redirect_pc = 32'h200;
      step(); chk_bubble("to_beq", 32'h200);
      redirect = 1'b0; stall = 1'b1;
      upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1;
      step(); chk_bubble("beq_stall0", 32'h200);
      step(); chk_bubble("beq_stall1", 32'h200);
      stall = 1'b0; upd_valid = 1'b0;
      step(); chk_fetch("beq_taken", 32'h210, 32'h200, 2'b11, 1'b1);

      for (int i = 0; i < 4; i++) begin
         redirect = 1'b1; redirect_pc = 32'h200;
         upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b0;
         step();
         redirect = 1'b0; upd_valid = 1'b0;
         step(); chk_fetch("beq_nt_sat", nt_addr[i], 32'h200, nt_bp[i], 1'b1);
      end

      redirect = 1'b1; redirect_pc = 32'h200;
      step();
      redirect = 1'b0; upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1;
      step(); chk_fetch("same_cycle_old", 32'h204, 32'h200, 2'b00, 1'b1);
      upd_valid = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      step(); chk_fetch("same_cycle_new", 32'h204, 32'h200, 2'b01, 1'b1);

      upd_valid = 1'b1; upd_pc = 32'h304; upd_taken = 1'b1;
      step();
      step();
      upd_valid = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h304;
      step();
      redirect = 1'b0;
      step(); chk_fetch("beq_neg", 32'h2FC, 32'h304, 2'b11, 1'b1);
`else
      redirect = 1'b1; redirect_pc = 32'h200;
      step(); chk_bubble("to_beq", 32'h200);
      redirect = 1'b0; upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1;
      step(); chk_fetch("nobht_beq0", 32'h204, 32'h200, 2'b01, 1'b1);
      redirect = 1'b1; redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      step(); chk_fetch("nobht_beq1", 32'h204, 32'h200, 2'b01, 1'b1);
      upd_valid = 1'b0;
      step(); chk_fetch("nobht_seq", 32'h208, 32'h204, 2'b01, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
